// File: rtl/turfio_pkg.sv
// Shared definitions for the TURFIO receive path.
//   align_state_t                : aligner FSM states
//   TURFIO_TRAIN_PATTERN_DEFAULT : training word, byte 0 ([7:0]) first on the wire
package turfio_pkg;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } align_state_t;

  localparam logic [31:0] TURFIO_TRAIN_PATTERN_DEFAULT = 32'hA55A6996;

endpackage

// File: rtl/turfio_bit_rotator.sv
// Fabric-side bit slip: rotates each valid byte across the previous one.
//   phy_clk    : PHY fabric clock
//   rst        : synchronous, active-high reset
//   din        : raw byte from the PHY
//   din_valid  : byte qualifier
//   off        : bit offset 0..7, dout = {prev,din}[7+off:off]
//   dout       : rotated byte, registered
//   dout_valid : one cycle after din_valid
module turfio_bit_rotator (
  input  logic       phy_clk,
  input  logic       rst,
  input  logic [7:0] din,
  input  logic       din_valid,
  input  logic [2:0] off,
  output logic [7:0] dout,
  output logic       dout_valid
);

  logic [7:0]       prev;
  logic [15:0]      pair;
  logic [7:0][7:0]  tap;
  logic             unused_prev_msb;

  assign pair = {prev, din};

  // One candidate byte per offset; off selects among them.
  for (genvar k = 0; k < 8; k++) begin : g_tap
    assign tap[k] = pair[k +: 8];
  end

  // The widest rotation reaches bit 14, so prev[7] never feeds the output.
  assign unused_prev_msb = pair[15];

  always_ff @(posedge phy_clk) begin
    if (rst) begin
      prev       <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
    end else begin
      dout_valid <= din_valid;
      if (din_valid) begin
        prev <= din;
        dout <= tap[off];
      end
    end
  end

endmodule

// File: rtl/turfio_rx_aligner.sv
// TURFIO RX word aligner: finds bit offset and byte phase of the repeating
// training word, locks, then emits aligned 32-bit words.
//   phy_clk, rst            : clock, synchronous active-high reset
//   data_to_fabric          : byte from the PHY, qualified by fifo_data_valid
//   retrain                 : pulse, return to HUNT (keeps bit_offset)
//   train_en                : far end is sending training words
//   dout / dout_valid       : aligned word {b3,b2,b1,b0} + strobe (LOCKED only)
//   locked                  : FSM is in LOCKED
//   bit_offset              : current rotation
//   err_count               : training mismatches while locked
// Build option: TURFIO_ALIGN_ERRCNT_EN enables err_count; otherwise it is 0.
module turfio_rx_aligner
  import turfio_pkg::*;
#(
  parameter logic [31:0] TRAIN_PATTERN = TURFIO_TRAIN_PATTERN_DEFAULT,
  parameter int          HUNT_TIMEOUT  = 32,
  parameter int          LOCK_COUNT    = 4
) (
  input  logic        phy_clk,
  input  logic        rst,
  input  logic [7:0]  data_to_fabric,
  input  logic        fifo_data_valid,
  input  logic        retrain,
  input  logic        train_en,
  output logic [31:0] dout,
  output logic        dout_valid,
  output logic        locked,
  output logic [2:0]  bit_offset,
  output logic [15:0] err_count
);

  localparam int HW = $clog2(HUNT_TIMEOUT + 1);

  align_state_t  state, state_nxt;
  logic [7:0]    rot;
  logic          rot_vld;
  logic [31:0]   window, win_nxt;
  logic [1:0]    phase;
  logic [HW-1:0] hunt_cnt;
  logic [3:0]    match_cnt;
  logic          pat_hit, word_done;
  logic          hunt_clr, hunt_inc, off_inc;
  logic          match_clr, match_load, match_inc;
  logic          phase_sync, load_out, err_inc;

  turfio_bit_rotator u_rot (
    .phy_clk    (phy_clk),
    .rst        (rst),
    .din        (data_to_fabric),
    .din_valid  (fifo_data_valid),
    .off        (bit_offset),
    .dout       (rot),
    .dout_valid (rot_vld)
  );

  // Compare against the window as it will be after this byte, so decisions
  // land in the same cycle the byte enters the window.
  assign win_nxt   = {rot, window[31:8]};
  assign pat_hit   = (win_nxt == TRAIN_PATTERN);
  assign word_done = rot_vld && (phase == 2'd3);
  assign locked    = (state == LOCKED);

  always_ff @(posedge phy_clk) begin
    if (rst) state <= HUNT;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    hunt_clr   = 1'b0;
    hunt_inc   = 1'b0;
    off_inc    = 1'b0;
    match_clr  = 1'b0;
    match_load = 1'b0;
    match_inc  = 1'b0;
    phase_sync = 1'b0;
    load_out   = 1'b0;
    err_inc    = 1'b0;
    if (retrain) begin
      state_nxt = HUNT;
      hunt_clr  = 1'b1;
      match_clr = 1'b1;
    end else if (rot_vld) begin
      unique case (state)
        HUNT: begin
          // A hit takes priority over a timeout in the same byte.
          if (pat_hit) begin
            state_nxt  = VERIFY;
            match_load = 1'b1;
            phase_sync = 1'b1;
            hunt_clr   = 1'b1;
          end else if (hunt_cnt == HW'(HUNT_TIMEOUT - 1)) begin
            off_inc  = 1'b1;
            hunt_clr = 1'b1;
          end else begin
            hunt_inc = 1'b1;
          end
        end
        VERIFY: begin
          // The HUNT hit loads 1; lock on the matching word that arrives once
          // the count already stands at LOCK_COUNT.
          if (word_done) begin
            if (!pat_hit) begin
              state_nxt = HUNT;
              hunt_clr  = 1'b1;
            end else if (match_cnt == 4'(LOCK_COUNT)) begin
              state_nxt = LOCKED;
            end else begin
              match_inc = 1'b1;
            end
          end
        end
        LOCKED: begin
          if (word_done) begin
            load_out = 1'b1;
            err_inc  = train_en && !pat_hit;
          end
        end
        default: state_nxt = HUNT;
      endcase
    end
  end

  always_ff @(posedge phy_clk) begin
    if (rst) begin
      window     <= '0;
      phase      <= '0;
      hunt_cnt   <= '0;
      match_cnt  <= '0;
      bit_offset <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
    end else begin
      dout_valid <= 1'b0;
      // Window and phase track every byte, even one that coincides with retrain.
      if (rot_vld) begin
        window <= win_nxt;
        phase  <= phase_sync ? 2'd0 : phase + 2'd1;
      end
      if (hunt_clr)      hunt_cnt <= '0;
      else if (hunt_inc) hunt_cnt <= hunt_cnt + HW'(1);
      if (match_clr)       match_cnt <= '0;
      else if (match_load) match_cnt <= 4'd1;
      else if (match_inc)  match_cnt <= match_cnt + 4'd1;
      if (off_inc) bit_offset <= bit_offset + 3'd1;
      if (load_out) begin
        dout       <= win_nxt;
        dout_valid <= 1'b1;
      end
    end
  end

`ifdef TURFIO_ALIGN_ERRCNT_EN
  logic [15:0] err_q;

  always_ff @(posedge phy_clk) begin
    if (rst || retrain)                    err_q <= '0;
    else if (err_inc && err_q != 16'hFFFF) err_q <= err_q + 16'd1;
  end

  assign err_count = err_q;
`else
  logic unused_err;

  assign unused_err = err_inc;
  assign err_count  = '0;
`endif

endmodule

// File: tb/tb_turfio_rx_aligner.sv
module tb_turfio_rx_aligner;

  localparam logic [31:0] PAT = 32'hA55A6996;
`ifdef TURFIO_ALIGN_ERRCNT_EN
  localparam logic [31:0] ERR_EXP = 32'd3;
`else
  localparam logic [31:0] ERR_EXP = 32'd0;
`endif

  logic        phy_clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  data_to_fabric = '0;
  logic        fifo_data_valid = 1'b0;
  logic        retrain = 1'b0;
  logic        train_en = 1'b0;
  logic [31:0] dout;
  logic        dout_valid;
  logic        locked;
  logic [2:0]  bit_offset;
  logic [15:0] err_count;

  int          total = 0;
  int          bad = 0;
  int          strobes = 0;
  logic [31:0] last_dout = '0;
  int          idx = 0;
  int          sj = 0;
  int          cs = -1;
  int          ce = -1;

  turfio_rx_aligner dut (
    .phy_clk         (phy_clk),
    .rst             (rst),
    .data_to_fabric  (data_to_fabric),
    .fifo_data_valid (fifo_data_valid),
    .retrain         (retrain),
    .train_en        (train_en),
    .dout            (dout),
    .dout_valid      (dout_valid),
    .locked          (locked),
    .bit_offset      (bit_offset),
    .err_count       (err_count)
  );

  always #5 phy_clk = ~phy_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock; sample #1 after the edge and log any word strobe.
  task automatic tick();
    @(posedge phy_clk);
    #1;
    if (dout_valid === 1'b1) begin
      strobes++;
      last_dout = dout;
    end
  endtask

  task automatic drive(input logic [7:0] b);
    data_to_fabric  = b;
    fifo_data_valid = 1'b1;
    tick();
    fifo_data_valid = 1'b0;
  endtask

  function automatic logic [7:0] pb(input int i);
    logic [31:0] p;
    p = PAT;
    return p[8*(i%4) +: 8];
  endfunction

  function automatic logic [7:0] tbyte(input int j);
    if (j >= cs && j < ce) return 8'h00;
    return pb(j);
  endfunction

  task automatic send_al();
    drive(pb(idx));
    idx++;
  endtask

  // Wire stream whose true bytes sit 3 bits into {prev,cur}.
  task automatic send_skew();
    logic [7:0] t0, t1;
    t0 = tbyte(sj);
    t1 = tbyte(sj + 1);
    drive({t0[4:0], t1[7:5]});
    sj++;
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    chk("rst_dout", dout, 32'h0);
    chk("rst_dvalid", {31'b0, dout_valid}, 32'd0);
    chk("rst_locked", {31'b0, locked}, 32'd0);
    chk("rst_off", {29'b0, bit_offset}, 32'd0);
    chk("rst_err", {16'b0, err_count}, 32'd0);
    rst = 1'b0;
    train_en = 1'b1;

    // Aligned lock: locked two cycles after byte 20
    idx = 0;
    for (int i = 0; i < 19; i++) send_al();
    send_al();
    chk("al_lock_early", {31'b0, locked}, 32'd0);
    tick();
    chk("al_lock", {31'b0, locked}, 32'd1);
    chk("al_off", {29'b0, bit_offset}, 32'd0);
    for (int i = 0; i < 4; i++) send_al();
    chk("al_no_strobe_yet", {31'b0, dout_valid}, 32'd0);
    tick();
    chk("al_strobe", {31'b0, dout_valid}, 32'd1);
    chk("al_dout", dout, PAT);
    tick();
    chk("al_strobe_1cyc", {31'b0, dout_valid}, 32'd0);

    // Retrain, then reset in the middle of VERIFY
    retrain = 1'b1;
    tick();
    retrain = 1'b0;
    chk("rt_unlock", {31'b0, locked}, 32'd0);
    for (int i = 0; i < 8; i++) send_al();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mv_rst_dout", dout, 32'h0);
    chk("mv_rst_locked", {31'b0, locked}, 32'd0);
    chk("mv_rst_dvalid", {31'b0, dout_valid}, 32'd0);
    chk("mv_rst_off", {29'b0, bit_offset}, 32'd0);

    // Gapped valid: same lock, one idle after every byte
    idx = 0;
    for (int i = 0; i < 19; i++) begin send_al(); tick(); end
    send_al();
    chk("gap_lock_early", {31'b0, locked}, 32'd0);
    tick();
    chk("gap_lock", {31'b0, locked}, 32'd1);
    strobes = 0;
    for (int i = 0; i < 16; i++) begin send_al(); tick(); end
    chk("gap_strobes", strobes, 32'd4);
    chk("gap_dout", last_dout, PAT);

    // Byte phase: stream starts with 0x69; hit at byte 7, lock after byte 23
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idx = 1;
    for (int i = 0; i < 22; i++) send_al();
    chk("ph_lock_early", {31'b0, locked}, 32'd0);
    send_al();
    tick();
    chk("ph_lock", {31'b0, locked}, 32'd1);
    strobes = 0;
    for (int i = 0; i < 12; i++) send_al();
    tick();
    chk("ph_strobes", strobes, 32'd3);
    chk("ph_dout", last_dout, PAT);

    // Offset search: 3-bit skew, offset steps every 32 bytes
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sj = 0;
    for (int i = 0; i < 32; i++) send_skew();
    tick(); tick();
    chk("sk_off1", {29'b0, bit_offset}, 32'd1);
    for (int i = 0; i < 32; i++) send_skew();
    tick(); tick();
    chk("sk_off2", {29'b0, bit_offset}, 32'd2);
    for (int i = 0; i < 32; i++) send_skew();
    tick(); tick();
    chk("sk_off3", {29'b0, bit_offset}, 32'd3);
    chk("sk_not_locked", {31'b0, locked}, 32'd0);
    for (int i = 0; i < 20; i++) send_skew();
    tick();
    chk("sk_lock", {31'b0, locked}, 32'd1);
    chk("sk_lock_off", {29'b0, bit_offset}, 32'd3);
    strobes = 0;
    for (int i = 0; i < 8; i++) send_skew();
    tick();
    chk("sk_strobes", strobes, 32'd2);
    chk("sk_dout", last_dout, PAT);

    // Error injection: three zeroed training words while locked
    cs = 128;
    ce = 140;
    strobes = 0;
    for (int i = 0; i < 20; i++) send_skew();
    tick();
    chk("err_count", {16'b0, err_count}, ERR_EXP);
    chk("err_locked", {31'b0, locked}, 32'd1);
    chk("err_strobes", strobes, 32'd5);
    chk("err_last_dout", last_dout, PAT);
    retrain = 1'b1;
    tick();
    retrain = 1'b0;
    chk("err_rt_locked", {31'b0, locked}, 32'd0);
    chk("err_rt_count", {16'b0, err_count}, 32'd0);
    chk("err_rt_off", {29'b0, bit_offset}, 32'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/turfio_rx_aligner.md
# turfio_rx_aligner

Receive-side word aligner for the TURFIO link. It sits directly downstream of the native RX PHY and consumes its 8-bit `data_to_fabric` stream and FIFO data-valid on the PHY fabric clock. It finds the bit offset and byte phase of a repeating 32-bit training word, declares lock, and then delivers aligned 32-bit words to the fabric. All bit correction is done in fabric by rotating across the previous byte, so the block needs no PHY bitslip handshake.

## Interface

Parameters:
- `TRAIN_PATTERN`, default 32'hA55A6996: the training word; byte 0 (bits [7:0]) is the first byte on the wire.
- `HUNT_TIMEOUT`, default 32: number of valid bytes without a match before `bit_offset` advances.
- `LOCK_COUNT`, default 4: number of consecutive matching words needed to lock (range 1–15).

Ports:
- `phy_clk`, in, 1: PHY fabric clock; the only clock.
- `rst`, in, 1: synchronous, active-high reset.
- `data_to_fabric`, in, 8: byte from the PHY.
- `fifo_data_valid`, in, 1: byte qualifier.
- `retrain`, in, 1: single-cycle pulse; forces HUNT.
- `train_en`, in, 1: high while the far end is sending training words.
- `dout`, out, 32: aligned word, `{b3,b2,b1,b0}`.
- `dout_valid`, out, 1: one-cycle strobe per word, asserted only in LOCKED.
- `locked`, out, 1: high in LOCKED.
- `bit_offset`, out, 3: current rotation.
- `err_count`, out, 16: training mismatch count.

## Operation

Bit rotation:
- On each valid byte, `rot = {prev,cur}[7+off:off]`, and `prev <= cur`.
- `off = 0` passes `cur` unchanged.

Window:
- A 4-byte shift register holds the rotated bytes.
- Each new rotated byte enters at [31:24]; the oldest byte drops out of [7:0].

Byte phase:
- A 2-bit counter counts rotated bytes.
- A word is complete when the counter wraps 3→0.

States: HUNT, VERIFY, LOCKED (enum).
- **HUNT**
  - Compare the window to `TRAIN_PATTERN` on every rotated byte.
  - On a match: set the phase so the next byte is b0, set the match count to 1, go to VERIFY.
  - Otherwise increment the hunt counter. When it reaches `HUNT_TIMEOUT`: `bit_offset <= bit_offset+1` (7 wraps to 0), and clear the hunt counter.
- **VERIFY**
  - On each completed word: a match increments the match count; at `LOCK_COUNT` go to LOCKED.
  - A mismatch goes to HUNT with the hunt counter cleared and `bit_offset` unchanged.
- **LOCKED**
  - On each completed word, load `dout` and pulse `dout_valid`.
  - Stays locked on mismatches; only `retrain` or `rst` leaves LOCKED.
- `retrain` goes to HUNT from any state:
  - clears the hunt counter, match count and `err_count`;
  - keeps `bit_offset`.
- Invalid cycles (`fifo_data_valid` = 0) change nothing: no rotation, no counter movement.

## Timing

- Reset values:
  - outputs: `dout` = 0, `dout_valid` = 0, `locked` = 0, `bit_offset` = 0, `err_count` = 0;
  - internal: state = HUNT, all counters 0, `prev` = 0, window = 0.
- Rotated byte is registered 1 cycle after its valid input byte.
- `dout`/`dout_valid` appear 2 cycles after the input byte that completes a word.
- `locked` rises in the same cycle as the state register enters LOCKED, 2 cycles after the final verifying input byte. The first `dout_valid` comes on the next completed word.
- `retrain` and a valid byte in the same cycle: `retrain` wins the state update, but the byte still updates `prev`, the window and the phase.
- The hunt-timeout increment and a HUNT match in the same cycle: the match wins and the offset is unchanged.
- Back-to-back valid bytes are supported at full rate: one byte per cycle, one word per 4 cycles.

## Configuration

Macro `TURFIO_ALIGN_ERRCNT_EN`.
- **Defined:** in LOCKED with `train_en` = 1, each completed word that is not equal to `TRAIN_PATTERN` increments `err_count`. The count saturates at 16'hFFFF and is cleared by `rst` or `retrain`.
- **Undefined:** `err_count` is tied to 0 and the counter logic is absent.

## Structure

- Shared package `turfio_pkg` holds:
  - the `align_state_t` enum (HUNT, VERIFY, LOCKED);
  - `TURFIO_TRAIN_PATTERN_DEFAULT` = 32'hA55A6996.
- Sub-module `turfio_bit_rotator` contains the prev-byte register plus the 8:1 rotation mux. It is 1-cycle registered, with ports `phy_clk`, `rst`, `din`, `din_valid`, `off`, `dout`, `dout_valid`.
- The top level holds the window, phase, counters, FSM and error counter.

## Test plan

- **Aligned lock:** aligned stream of A55A6996 words, `bit_offset` 0 → `locked` rises 2 cycles after byte 4 × (`LOCK_COUNT` + 1) = 20. `bit_offset` = 0.
- **Offset search:** stream skewed by 3 bits → `bit_offset` steps 0→1→2→3 every 32 bytes. It locks at 3, and `dout` = 32'hA55A6996 thereafter.
- **Byte phase:** aligned stream started mid-word (first byte 0x69) → lock with the correct phase. Every `dout` = 32'hA55A6996, one strobe per 4 bytes.
- **Gaps and reset:**
  - `fifo_data_valid` toggled 1/0 during lock → same result, with twice the latency in cycles.
  - `rst` asserted mid-VERIFY → all outputs return to reset values on the next cycle.
- **Error count:** locked, `train_en` = 1, then inject 3 corrupted words:
  - macro defined → `err_count` = 3 and `locked` stays 1;
  - then pulse `retrain` → `locked` = 0, `err_count` = 0, `bit_offset` retained.
- **Macro undefined:** same injection → `err_count` stays 0.
